trigger_event_latch: RTL and testbench
======================================

TRIGGER_EVENT_LATCH -- requirements
Module: trigger_event_latch

Interface
REQ-001 Parameter NUM_SRC, default 4, number of trigger sources.
REQ-002 Parameter TS_WIDTH, default 32, timestamp width.
REQ-003 Parameter FIFO_DEPTH, default 4, event buffer entries (power of 2).
REQ-004 CLK120  input  1  sole clock; all logic on posedge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 ENABLE  input  1  acceptance enable.
REQ-007 TRIG_IN  input  NUM_SRC  single-cycle trigger pulses from the trigger blocks (single-bin, ToT, etc.).
REQ-008 TRIG_MASK  input  NUM_SRC  per-source enable.
REQ-009 DEAD_TIME  input  16  cycles ignored after an accepted trigger.
REQ-010 EVT_ACK  input  1  readout pops the head entry.
REQ-011 TRIG_OUT  output  1  one-cycle pulse per accepted trigger.
REQ-012 EVT_VALID  output  1  FIFO non-empty.
REQ-013 EVT_TYPE  output  NUM_SRC  head entry source mask.
REQ-014 EVT_TIME  output  TS_WIDTH  head entry timestamp.
REQ-015 FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 LOST_COUNT  output  16  triggers dropped because the FIFO was full.

Function
REQ-017 The timestamp counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 The masked trigger SHALL be TRIG_IN & TRIG_MASK; a candidate exists when it is non-zero.
REQ-019 The FSM SHALL have two states, IDLE and DEAD.
REQ-020 IDLE with ENABLE=1, a candidate and FULL=0 SHALL accept the trigger:
- push {masked trigger, timestamp of that cycle};
- TRIG_OUT=1 in the next cycle only;
- load the dead counter with DEAD_TIME;
- go to DEAD if DEAD_TIME is non-zero, otherwise stay in IDLE.
REQ-021 IDLE with ENABLE=1, a candidate and FULL=1 SHALL increment LOST_COUNT, saturating at 0xFFFF, with no push, no TRIG_OUT and no state change.
REQ-022 DEAD SHALL ignore all candidates, which are neither pushed nor counted as lost.
REQ-023 DEAD SHALL decrement the dead counter each cycle and return to IDLE when it reaches 0.
REQ-024 Acceptance timing: after an acceptance at cycle t, candidates at t+1..t+DEAD_TIME are ignored and a candidate at t+DEAD_TIME+1 is eligible.
REQ-025 ENABLE=0 SHALL:
- force IDLE and clear the dead counter;
- suppress acceptance and lost counting;
- leave FIFO contents and the timestamp counter running and unaffected.
REQ-026 The FIFO SHALL be show-ahead: EVT_TYPE and EVT_TIME present the head entry whenever EVT_VALID=1.
REQ-027 A pop SHALL occur on a cycle with EVT_VALID=1 and EVT_ACK=1; EVT_ACK with EVT_VALID=0 SHALL be ignored.
REQ-028 FULL SHALL be evaluated before any same-cycle pop, so a candidate arriving while FULL=1 is lost even if EVT_ACK=1 in that cycle.
REQ-029 Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH SHALL leave occupancy unchanged.
REQ-030 Push into an empty FIFO SHALL make EVT_VALID=1 in the next cycle, coincident with TRIG_OUT.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 All outputs SHALL be registered.
REQ-033 Several bits set in the masked trigger in one cycle SHALL produce one event whose EVT_TYPE has all of those bits set.

Reset
REQ-034 RST_N=0 SHALL immediately set the following, independent of CLK120:
- TRIG_OUT, EVT_VALID, FULL = 0;
- EVT_TYPE, EVT_TIME, LOST_COUNT = 0;
- timestamp, dead counter and pointers = 0;
- state = IDLE.
REQ-035 Reset asserted mid-DEAD or with the FIFO non-empty SHALL discard all pending events and dead time.

Verification
REQ-036 Single accept: DEAD_TIME=5, mask=0xF, TRIG_IN=0x1 at timestamp 100 -> next cycle TRIG_OUT=1, EVT_VALID=1, EVT_TYPE=0x1, EVT_TIME=100.
REQ-037 Dead-time edge: DEAD_TIME=3, pulses at t, t+3 and t+4 -> accepted at t and t+4 only; t+3 ignored; LOST_COUNT=0.
REQ-038 Overflow: depth 4, no ACK, 6 pulses spaced by DEAD_TIME+1 -> 4 events, FULL=1, LOST_COUNT=2.
REQ-039 Pop while full: FULL=1 with EVT_ACK=1 and a candidate in the same cycle -> candidate lost (LOST_COUNT+1), occupancy becomes 3.
REQ-040 Masking and combination: TRIG_MASK=0x5, TRIG_IN=0x7 -> EVT_TYPE=0x5; TRIG_IN=0x2 alone -> no event.
REQ-041 Reset mid-DEAD: 2 entries queued and DEAD active, RST_N pulsed low -> all outputs 0 at once; a candidate in the first cycle after release is accepted with EVT_TIME equal to the post-reset timestamp.

Source files
------------

// File: rtl/trigger_event_latch.sv
// trigger_event_latch: timestamps masked triggers, enforces dead time and buffers events in a show-ahead FIFO.
module trigger_event_latch #(
    parameter int NUM_SRC    = 4,
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK120,
    input  logic                RST_N,
    input  logic                ENABLE,
    input  logic [NUM_SRC-1:0]  TRIG_IN,
    input  logic [NUM_SRC-1:0]  TRIG_MASK,
    input  logic [15:0]         DEAD_TIME,
    input  logic                EVT_ACK,
    output logic                TRIG_OUT,
    output logic                EVT_VALID,
    output logic [NUM_SRC-1:0]  EVT_TYPE,
    output logic [TS_WIDTH-1:0] EVT_TIME,
    output logic                FULL,
    output logic [15:0]         LOST_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {IDLE, DEAD} state_t;
    state_t               r_state;
    logic [15:0]          r_dead;
    logic [TS_WIDTH-1:0]  r_ts;
    logic [NUM_SRC-1:0]   r_mem_type [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]  r_mem_time [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;
    logic [NUM_SRC-1:0]   w_masked;
    logic                 w_req, w_push, w_lost, w_pop, w_bypass;
    logic [AW-1:0]        w_rptr_next;
    logic [CW-1:0]        w_count_next;
    assign w_masked     = TRIG_IN & TRIG_MASK;
    assign w_req        = ENABLE && (r_state == IDLE) && (|w_masked);
    // FULL is the registered flag, so a same-cycle pop cannot rescue a candidate
    assign w_push       = w_req && !FULL;
    assign w_lost       = w_req && FULL;
    assign w_pop        = EVT_VALID && EVT_ACK;
    assign w_rptr_next  = r_rptr + AW'(w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    // new head is the entry being written when the FIFO is (or becomes) empty
    assign w_bypass     = w_push && (r_count == CW'(w_pop));
    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_dead     <= '0;
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            TRIG_OUT   <= 1'b0;
            EVT_VALID  <= 1'b0;
            EVT_TYPE   <= '0;
            EVT_TIME   <= '0;
            FULL       <= 1'b0;
            LOST_COUNT <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_type[i] <= '0;
                r_mem_time[i] <= '0;
            end
        end else begin
            r_ts     <= r_ts + TS_WIDTH'(1);
            TRIG_OUT <= w_push;
            if (w_lost && LOST_COUNT != 16'hFFFF)
                LOST_COUNT <= LOST_COUNT + 16'd1;
            if (!ENABLE) begin
                r_state <= IDLE;
                r_dead  <= '0;
            end else if (r_state == IDLE) begin
                if (w_push) begin
                    r_dead  <= DEAD_TIME;
                    r_state <= (DEAD_TIME != 16'd0) ? DEAD : IDLE;
                end
            end else begin
                r_dead <= r_dead - 16'(r_dead != 16'd0);
                if (r_dead <= 16'd1)
                    r_state <= IDLE;
            end
            if (w_push) begin
                r_mem_type[r_wptr] <= w_masked;
                r_mem_time[r_wptr] <= r_ts;
                r_wptr             <= r_wptr + AW'(1);
            end
            r_rptr    <= w_rptr_next;
            r_count   <= w_count_next;
            EVT_VALID <= w_count_next != '0;
            FULL      <= w_count_next == CW'(FIFO_DEPTH);
            EVT_TYPE  <= w_bypass ? w_masked : r_mem_type[w_rptr_next];
            EVT_TIME  <= w_bypass ? r_ts : r_mem_time[w_rptr_next];
        end
    end
endmodule

// File: tb/tb_trigger_event_latch.sv
// tb_trigger_event_latch: directed checks of acceptance, dead time, overflow, masking and reset.
module tb_trigger_event_latch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  trig_in = '0;
    logic [3:0]  trig_mask = 4'hF;
    logic [15:0] dead_time = 16'd5;
    logic        evt_ack = 1'b0;
    logic        trig_out, evt_valid, full;
    logic [3:0]  evt_type;
    logic [31:0] evt_time;
    logic [15:0] lost_count;
    logic [31:0] ts;
    logic [31:0] ev [6];
    int          n_vec = 0;
    int          n_err = 0;

    trigger_event_latch dut (
        .CLK120(clk), .RST_N(rst_n), .ENABLE(enable), .TRIG_IN(trig_in),
        .TRIG_MASK(trig_mask), .DEAD_TIME(dead_time), .EVT_ACK(evt_ack),
        .TRIG_OUT(trig_out), .EVT_VALID(evt_valid), .EVT_TYPE(evt_type),
        .EVT_TIME(evt_time), .FULL(full), .LOST_COUNT(lost_count)
    );

    always #5 clk = ~clk;

    // reference free-running timestamp
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ts <= '0;
        else        ts <= ts + 32'd1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        trig_in = v;
        tick();
        trig_in = '0;
    endtask

    task automatic pop();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_trig_out", 32'(trig_out), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_time", evt_time, 32'd0);
        chk("rst_lost", 32'(lost_count), 32'd0);
        tick(2);
        rst_n = 1'b1;

        // single accept at timestamp 100
        dead_time = 16'd5;
        for (int i = 0; i < 200 && ts != 32'd100; i++) tick();
        chk("ts_reach_100", ts, 32'd100);
        pulse(4'h1);
        chk("single_trig_out", 32'(trig_out), 32'd1);
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_type", 32'(evt_type), 32'h1);
        chk("single_time", evt_time, 32'd100);
        tick();
        chk("single_trig_out_drop", 32'(trig_out), 32'd0);
        pop();
        chk("single_popped", 32'(evt_valid), 32'd0);
        tick(8);

        // dead-time edge: pulses at t, t+3, t+4 with DEAD_TIME=3
        dead_time = 16'd3;
        ev[0] = ts;
        pulse(4'h1);
        chk("dt_first", 32'(trig_out), 32'd1);
        tick(2);
        pulse(4'h1);
        chk("dt_t3_ignored", 32'(trig_out), 32'd0);
        ev[1] = ts;
        pulse(4'h1);
        chk("dt_t4_accepted", 32'(trig_out), 32'd1);
        chk("dt_t4_time", ev[1], ev[0] + 32'd4);
        chk("dt_lost", 32'(lost_count), 32'd0);
        chk("dt_head", evt_time, ev[0]);
        pop();
        chk("dt_head2", evt_time, ev[1]);
        chk("dt_valid2", 32'(evt_valid), 32'd1);
        pop();
        chk("dt_empty", 32'(evt_valid), 32'd0);
        tick(5);

        // masking and combination
        trig_mask = 4'h5;
        pulse(4'h7);
        chk("mask_trig_out", 32'(trig_out), 32'd1);
        chk("mask_type", 32'(evt_type), 32'h5);
        pop();
        tick(5);
        pulse(4'h2);
        chk("mask_none_trig", 32'(trig_out), 32'd0);
        chk("mask_none_valid", 32'(evt_valid), 32'd0);
        trig_mask = 4'hF;

        // ENABLE=0 suppresses acceptance
        enable = 1'b0;
        pulse(4'h1);
        chk("dis_trig_out", 32'(trig_out), 32'd0);
        chk("dis_valid", 32'(evt_valid), 32'd0);
        enable = 1'b1;
        tick();

        // overflow: 6 pulses spaced DEAD_TIME+1 with no ack
        dead_time = 16'd3;
        for (int k = 0; k < 6; k++) begin
            ev[k] = ts;
            pulse(4'h8);
            tick(3);
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_lost", 32'(lost_count), 32'd2);
        chk("ovf_head", evt_time, ev[0]);
        chk("ovf_type", 32'(evt_type), 32'h8);

        // pop while full with a same-cycle candidate
        evt_ack = 1'b1;
        trig_in = 4'h1;
        tick();
        evt_ack = 1'b0;
        trig_in = '0;
        chk("pwf_lost", 32'(lost_count), 32'd3);
        chk("pwf_full", 32'(full), 32'd0);
        chk("pwf_trig_out", 32'(trig_out), 32'd0);
        chk("pwf_head", evt_time, ev[1]);
        pop();
        pop();
        chk("pwf_valid_last", 32'(evt_valid), 32'd1);
        chk("pwf_head_last", evt_time, ev[3]);
        pop();
        chk("pwf_empty", 32'(evt_valid), 32'd0);
        tick(3);

        // reset mid-DEAD with two entries queued
        dead_time = 16'd20;
        pulse(4'h1);
        tick(21);
        pulse(4'h2);
        tick(2);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_trig_out", 32'(trig_out), 32'd0);
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_type", 32'(evt_type), 32'd0);
        chk("arst_time", evt_time, 32'd0);
        chk("arst_lost", 32'(lost_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev[0] = ts;
        pulse(4'h4);
        chk("post_rst_trig_out", 32'(trig_out), 32'd1);
        chk("post_rst_time", evt_time, ev[0]);
        chk("post_rst_time_zero", evt_time, 32'd0);
        chk("post_rst_type", 32'(evt_type), 32'h4);
        pop();
        chk("post_rst_empty", 32'(evt_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
